hack_data_memory: RTL and testbench
===================================

# hack_data_memory

Data-side responder for the 16-bit Hack CPU: serves the CPU's `addressM`/`outM`/`writeM` bus and returns `inM` in the same cycle. It maps 16K words of RAM, an 8K-word screen framebuffer and a keyboard register. It also streams the framebuffer to a display sink over a valid/ready scan port. The block sits beside the CPU in the top-level computer; instruction ROM is out of scope.

## Interface
- `RAM_WORDS`, 16384: general RAM depth, words at 0x0000–0x3FFF.
- `SCREEN_WORDS`, 8192: framebuffer depth, words at 0x4000–0x5FFF.
- `KBD_ADDR`, 15'h6000: keyboard register address.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addressM`  in  15  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write strobe.
- `inM`  out  16  read data to CPU; combinational from `addressM`.
- `key_valid`  in  1  keyboard source has a code.
- `key_code`  in  16  scan code; 0 = no key pressed.
- `key_ready`  out  1  keyboard register accepts a code.
- `scan_valid`  out  1  `scan_data` holds a framebuffer word.
- `scan_ready`  in  1  display sink accepts the word.
- `scan_data`  out  16  framebuffer word.
- `scan_addr`  out  13  index of `scan_data` within the framebuffer.
- `frame_start`  out  1  high while `scan_addr` == 0 and `scan_valid`.
- `bad_addr`  out  1  sticky flag: CPU access above `KBD_ADDR`.

## Operation
- Decode on `addressM[14:13]`: 00/01 → RAM, 10 → screen, 11 → keyboard only when `addressM` == `KBD_ADDR`, else unmapped.
- Read: `inM` = selected word; keyboard read returns the `kbd` register; unmapped read returns 0.
- Write: when `writeM` = 1, write `outM` to RAM or screen at the clock edge. Writes to `KBD_ADDR` or to unmapped addresses are ignored.
- `bad_addr` sets on any cycle where `addressM` > `KBD_ADDR` and either `writeM` = 1 or a read is decoded. Only `reset` clears it.
- Keyboard: `key_ready` = !reset. When `key_valid` && `key_ready`, `kbd` <= `key_code` at the edge.
- Scanner, two states:
  - SCAN_IDLE: entered on reset. Always moves to SCAN_RUN on the next cycle. Issues a fetch of index 0.
  - SCAN_RUN: `scan_valid` = 1.
    - On `scan_valid` && `scan_ready`: `scan_addr` increments, wrapping 8191 → 0, and `scan_data` loads `screen[next index]`.
    - Without `scan_ready`: `scan_data` and `scan_addr` hold; the held word is a snapshot and does not reflect later CPU writes.
- Reset values: `scan_valid` 0, `scan_addr` 0, `scan_data` 0, `frame_start` 0, `kbd` 0, `bad_addr` 0, `key_ready` 0 during reset.
- RAM and screen contents are not cleared by reset.

## Timing
- `inM` has zero-cycle latency from `addressM`.
- A write is visible on `inM` from the cycle after the write edge.
- Same-address read during write: `inM` shows the old value until the edge.
- Scanner fetch is a registered read with 1-cycle latency.
- Scanner fetch colliding with a CPU write to the same screen index in the same cycle: the scanner gets the old value (read-before-write).
- First `scan_valid` = 1 occurs on the second cycle after `reset` deasserts: one cycle in SCAN_IDLE, then data.
- Throughput is one word per cycle with `scan_ready` held high. A full frame is 8192 cycles; `frame_start` recurs every 8192 accepted words.
- Reset mid-frame: at the next edge the scanner returns to SCAN_IDLE with `scan_addr` 0. `kbd` clears. Memory arrays are untouched.
- Simultaneous `key_valid` and a CPU read of `KBD_ADDR`: the CPU sees the old `kbd` that cycle and the new code from the next cycle.

## Structure
- Shared package `hack_pkg`: address-map constants (`RAM_BASE`, `SCREEN_BASE`, `KBD_ADDR`, word counts), the `WORD_W`=16 constant, and the scanner state enum.
- One sub-module, `screen_scanner`:
  - Owns the scanner state machine, `scan_addr` counter and handshake.
  - Drives a read index into the framebuffer's second read port and registers the returned word.
- The framebuffer array lives in `hack_data_memory` so the CPU write port and the scanner read port share it.

## Test plan
- RAM: write 0x1234 to address 0x0005; next cycle read 0x0005 → `inM` = 0x1234. Read of 0x0006 is unaffected.
- Screen and scan:
  - Write 0xAAAA to 0x4000 and 0x5555 to 0x5FFF, then reset.
  - With `scan_ready` = 1: first valid word is 0xAAAA with `frame_start` = 1.
  - Word 8191 is 0x5555; the next word is 0xAAAA with `frame_start` = 1 again.
- Backpressure:
  - Hold `scan_ready` = 0 at `scan_addr` 3.
  - CPU writes 0xFFFF to 0x4003 → `scan_data` unchanged.
  - The next frame shows 0xFFFF at index 3.
- Keyboard: `key_valid` = 1 with `key_code` 0x0083 for one cycle → read of 0x6000 returns 0x0083 the next cycle. Later `key_code` 0 → read returns 0.
- Unmapped:
  - Write 0x7777 to 0x6001 → `bad_addr` = 1 next cycle and stays set.
  - Reads of 0x6001 return 0; RAM and screen are unchanged.
  - `reset` clears `bad_addr`.
- Reset mid-frame: assert `reset` at `scan_addr` 100 → the following cycle `scan_valid` = 0 and `scan_addr` = 0. RAM word 0x0005 still reads 0x1234.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack data-side memory map.
// Address decode lives here so the top and any future master agree on the map.
package hack_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned RAM_WORDS    = 16384;
  localparam int unsigned SCREEN_WORDS = 8192;
  localparam int unsigned RAM_IDX_W    = $clog2(RAM_WORDS);
  localparam int unsigned SCR_IDX_W    = $clog2(SCREEN_WORDS);

  localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [0:0] {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_SCREEN,
    SEL_KBD,
    SEL_NONE
  } sel_e;

  function automatic sel_e decode_addr(input logic [ADDR_W-1:0] addr);
    sel_e sel;
    sel = SEL_NONE;
    unique case (addr[14:13])
      2'b00, 2'b01: sel = SEL_RAM;
      2'b10:        sel = SEL_SCREEN;
      2'b11:        sel = (addr == KBD_ADDR) ? SEL_KBD : SEL_NONE;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/screen_scanner.sv
// Framebuffer scan-out engine: walks the screen indices and presents each word
// on a valid/ready port, holding a registered snapshot under backpressure.
module screen_scanner
  import hack_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic [SCR_IDX_W-1:0] rd_idx,
  input  logic [WORD_W-1:0]    rd_data,
  output logic                 scan_valid,
  input  logic                 scan_ready,
  output logic [WORD_W-1:0]    scan_data,
  output logic [SCR_IDX_W-1:0] scan_addr,
  output logic                 frame_start
);

  scan_state_e            state_q, state_d;
  logic [SCR_IDX_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]      data_q, data_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_idx  = '0;
    unique case (state_q)
      SCAN_IDLE: begin
        state_d = SCAN_RUN;
        addr_d  = '0;
        data_d  = rd_data;
      end
      SCAN_RUN: begin
        // Look-ahead index; the counter wraps naturally at the framebuffer size.
        rd_idx = addr_q + SCR_IDX_W'(1);
        if (scan_ready) begin
          addr_d = rd_idx;
          data_d = rd_data;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign scan_valid  = (state_q == SCAN_RUN);
  assign scan_data   = data_q;
  assign scan_addr   = addr_q;
  assign frame_start = scan_valid && (addr_q == '0);

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-side responder: RAM, screen framebuffer and keyboard register,
// with a scan-out port streaming the framebuffer to a display sink.
module hack_data_memory
  import hack_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    addressM,
  input  logic [WORD_W-1:0]    outM,
  input  logic                 writeM,
  output logic [WORD_W-1:0]    inM,
  input  logic                 key_valid,
  input  logic [WORD_W-1:0]    key_code,
  output logic                 key_ready,
  output logic                 scan_valid,
  input  logic                 scan_ready,
  output logic [WORD_W-1:0]    scan_data,
  output logic [SCR_IDX_W-1:0] scan_addr,
  output logic                 frame_start,
  output logic                 bad_addr
);

  logic [WORD_W-1:0] ram_mem    [RAM_WORDS];
  logic [WORD_W-1:0] screen_mem [SCREEN_WORDS];

  sel_e                 sel;
  logic [RAM_IDX_W-1:0] ram_idx;
  logic [SCR_IDX_W-1:0] cpu_scr_idx;
  logic [SCR_IDX_W-1:0] scan_rd_idx;
  logic [WORD_W-1:0]    scan_rd_data;
  logic [WORD_W-1:0]    kbd_q, kbd_d;
  logic                 bad_addr_q, bad_addr_d;

  assign sel         = decode_addr(addressM);
  assign ram_idx     = addressM[RAM_IDX_W-1:0];
  assign cpu_scr_idx = addressM[SCR_IDX_W-1:0];

  always_comb begin
    inM = '0;
    unique case (sel)
      SEL_RAM:    inM = ram_mem[ram_idx];
      SEL_SCREEN: inM = screen_mem[cpu_scr_idx];
      SEL_KBD:    inM = kbd_q;
      default:    inM = '0;
    endcase
  end

  // Arrays carry no reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (writeM && (sel == SEL_RAM)) begin
      ram_mem[ram_idx] <= outM;
    end
    if (writeM && (sel == SEL_SCREEN)) begin
      screen_mem[cpu_scr_idx] <= outM;
    end
  end

  // Combinational second read port; the scanner registers the word, which
  // yields read-before-write against a same-cycle CPU write.
  assign scan_rd_data = screen_mem[scan_rd_idx];

  assign key_ready = !reset;

  always_comb begin
    kbd_d = kbd_q;
    if (key_valid && key_ready) begin
      kbd_d = key_code;
    end
    // No read strobe exists, so every cycle is a decoded read of addressM.
    bad_addr_d = bad_addr_q || (addressM > KBD_ADDR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q      <= '0;
      bad_addr_q <= 1'b0;
    end else begin
      kbd_q      <= kbd_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign bad_addr = bad_addr_q;

  screen_scanner u_scanner (
    .clk         (clk),
    .reset       (reset),
    .rd_idx      (scan_rd_idx),
    .rd_data     (scan_rd_data),
    .scan_valid  (scan_valid),
    .scan_ready  (scan_ready),
    .scan_data   (scan_data),
    .scan_addr   (scan_addr),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_hack_data_memory.sv
// Scoreboard bench for hack_data_memory: a rules-level memory-map model predicts
// every cycle's outputs; a separate monitor compares them mid-cycle.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic        key_valid = 1'b0;
  logic [15:0] key_code = '0;
  logic        key_ready;
  logic        scan_valid;
  logic        scan_ready = 1'b0;
  logic [15:0] scan_data;
  logic [12:0] scan_addr;
  logic        frame_start;
  logic        bad_addr;

  hack_data_memory dut (
    .clk         (clk),
    .reset       (reset),
    .addressM    (addressM),
    .outM        (outM),
    .writeM      (writeM),
    .inM         (inM),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .scan_valid  (scan_valid),
    .scan_ready  (scan_ready),
    .scan_data   (scan_data),
    .scan_addr   (scan_addr),
    .frame_start (frame_start),
    .bad_addr    (bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        skip;
    logic        inm_chk;
    logic        sd_chk;
    logic        kr;
    logic        sv;
    logic        fs;
    logic        bad;
    logic [15:0] inm;
    logic [15:0] sd;
    logic [12:0] sa;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int n_bad = 0;

  // Reference state: known memory words keyed by CPU address.
  logic [15:0] mem_m [int];
  logic [15:0] kbd_m = '0;
  logic        bad_m = 1'b0;
  logic        sv_m = 1'b0;
  int          sa_m = 0;
  logic [15:0] sd_m = '0;
  logic        sd_k = 1'b0;
  logic        started = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fetch(input int idx);
    sd_k = mem_m.exists(32'h4000 + idx);
    if (sd_k) sd_m = mem_m[32'h4000 + idx];
  endtask

  task automatic cycle(input logic r, input logic [14:0] a, input logic [15:0] d,
                       input logic w, input logic kv, input logic [15:0] kc,
                       input logic sr);
    exp_t it;
    int   ai;
    @(posedge clk);
    #1;
    reset = r; addressM = a; outM = d; writeM = w;
    key_valid = kv; key_code = kc; scan_ready = sr;
    ai = int'(a);
    it = '0;
    it.skip = !started;
    it.kr   = !r;
    if (ai < 32'h6000) begin
      it.inm_chk = mem_m.exists(ai);
      it.inm     = it.inm_chk ? mem_m[ai] : 16'h0;
    end else if (ai == 32'h6000) begin
      it.inm_chk = 1'b1;
      it.inm     = kbd_m;
    end else begin
      it.inm_chk = 1'b1;
      it.inm     = 16'h0;
    end
    it.sv     = sv_m;
    it.sa     = 13'(sa_m);
    it.sd     = sd_m;
    it.sd_chk = sd_k;
    it.fs     = sv_m && (sa_m == 0);
    it.bad    = bad_m;
    exp_q.push_back(it);
    // State after the coming edge; scanner reads before this cycle's write lands.
    if (r) begin
      sv_m = 1'b0; sa_m = 0; sd_m = '0; sd_k = 1'b1;
      kbd_m = '0; bad_m = 1'b0; started = 1'b1;
    end else begin
      if (!sv_m) begin
        fetch(0); sv_m = 1'b1; sa_m = 0;
      end else if (sr) begin
        sa_m = (sa_m + 1) % 8192;
        fetch(sa_m);
      end
      if (ai > 32'h6000) bad_m = 1'b1;
      if (kv) kbd_m = kc;
    end
    if (w && ai < 32'h6000) mem_m[ai] = d;
  endtask

  always @(negedge clk) begin
    exp_t it;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      if (!it.skip) begin
        if (it.inm_chk) chk("inM", inM, it.inm);
        chk("key_ready", 16'(key_ready), 16'(it.kr));
        chk("scan_valid", 16'(scan_valid), 16'(it.sv));
        chk("scan_addr", 16'(scan_addr), 16'(it.sa));
        if (it.sd_chk) chk("scan_data", scan_data, it.sd);
        chk("frame_start", 16'(frame_start), 16'(it.fs));
        chk("bad_addr", 16'(bad_addr), 16'(it.bad));
      end
    end
  end

  initial begin
    logic [14:0] a;
    int          cat;
    // Reset, and fill the framebuffer and a RAM window while held in reset.
    cycle(1, 15'h0, 16'h0, 0, 0, 16'h0, 0);
    cycle(1, 15'h0, 16'h0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 8192; i++) begin
      cycle(1, 15'(32'h4000 + i),
            (i == 0) ? 16'hAAAA : (i == 8191) ? 16'h5555 : 16'($urandom),
            1, 0, 16'h0, 0);
    end
    for (int i = 0; i < 64; i++) cycle(1, 15'(i), 16'($urandom), 1, 0, 16'h0, 0);

    // RAM write/read, then a full frame plus wrap with the sink always ready.
    cycle(0, 15'h0005, 16'h1234, 1, 0, 16'h0, 1);
    cycle(0, 15'h0005, 16'h0, 0, 0, 16'h0, 1);
    cycle(0, 15'h0006, 16'h0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 8196; i++) begin
      cycle(0, (i % 2 == 0) ? 15'h0005 : 15'h4000, 16'h0, 0, 0, 16'h0, 1);
    end

    // Backpressure at index 3 with a CPU write to the held word.
    while (sa_m != 3) cycle(0, 15'h0006, 16'h0, 0, 0, 16'h0, 1);
    cycle(0, 15'h4003, 16'hFFFF, 1, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 15'h4003, 16'h0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 8194; i++) cycle(0, 15'h4003, 16'h0, 0, 0, 16'h0, 1);

    // Keyboard: load coincides with a read of the register.
    cycle(0, 15'h6000, 16'h0, 0, 1, 16'h0083, 1);
    cycle(0, 15'h6000, 16'h0, 0, 0, 16'h0, 1);
    cycle(0, 15'h6000, 16'h0, 0, 1, 16'h0000, 1);
    cycle(0, 15'h6000, 16'h0, 0, 0, 16'h0, 1);

    // Unmapped write, sticky flag, then reset clears it.
    cycle(0, 15'h6001, 16'h7777, 1, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 15'h6001, 16'h0, 0, 0, 16'h0, 1);
    cycle(0, 15'h0005, 16'h0, 0, 0, 16'h0, 1);
    cycle(0, 15'h4003, 16'h0, 0, 0, 16'h0, 1);
    cycle(1, 15'h0005, 16'h0, 0, 0, 16'h0, 1);
    cycle(0, 15'h0005, 16'h0, 0, 0, 16'h0, 1);

    // Randomized traffic, including writes near the scanner's look-ahead index.
    for (int i = 0; i < 3000; i++) begin
      cat = int'($urandom_range(0, 9));
      if (cat <= 2) a = 15'($urandom_range(0, 63));
      else if (cat <= 4) a = 15'(32'h4000 + ((sa_m + 1 + int'($urandom_range(0, 2))) % 8192));
      else if (cat <= 6) a = 15'(32'h4000 + $urandom_range(0, 8191));
      else if (cat == 7) a = 15'h6000;
      else if (cat == 8 && $urandom_range(0, 19) == 0) a = 15'(32'h6001 + $urandom_range(0, 8190));
      else a = 15'($urandom_range(0, 16383));
      cycle($urandom_range(0, 499) == 0, a, 16'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) != 0);
    end

    // Reset mid-frame: scanner restarts, memory contents persist.
    cycle(0, 15'h0005, 16'h1234, 1, 0, 16'h0, 1);
    while (sa_m != 100) cycle(0, 15'h0005, 16'h0, 0, 0, 16'h0, 1);
    cycle(1, 15'h0005, 16'h0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 15'h0005, 16'h0, 0, 0, 16'h0, 1);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
